// File: rtl/barrel_shift_pkg.sv
// rtl/barrel_shift_pkg.sv - op encodings and op-class helpers for the barrel shifter
package barrel_shift_pkg;

  localparam logic [2:0] OP_LSR = 3'd0;
  localparam logic [2:0] OP_LSL = 3'd1;
  localparam logic [2:0] OP_ASR = 3'd2;
  localparam logic [2:0] OP_ROR = 3'd3;
  localparam logic [2:0] OP_ROL = 3'd4;

  // Ops that move bits toward bit 0
  function automatic logic is_right(input logic [2:0] op);
    return (op == OP_LSR) || (op == OP_ASR) || (op == OP_ROR);
  endfunction

  // Ops that wrap the bits moved out back into the other end
  function automatic logic is_rotate(input logic [2:0] op);
    return (op == OP_ROR) || (op == OP_ROL);
  endfunction

  // Encodings above OP_ROL are pass-through
  function automatic logic is_shift_op(input logic [2:0] op);
    return op <= OP_ROL;
  endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// rtl/barrel_shift_stage.sv - one pipeline stage shifting by 2^STAGE_IDX
module barrel_shift_stage
  import barrel_shift_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STAGE_IDX = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_adv,
  input  logic                       i_valid,
  input  logic [WIDTH-1:0]           i_data,
  input  logic [$clog2(WIDTH)-1:0]   i_shamt,
  input  logic [2:0]                 i_op,
  input  logic                       i_carry,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(WIDTH)-1:0]   o_shamt,
  output logic [2:0]                 o_op,
  output logic                       o_carry,
  output logic                       o_zero
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int STEP    = 1 << STAGE_IDX;

  logic [WIDTH-1:0]   w_right;
  logic [WIDTH-1:0]   w_left;
  logic [WIDTH-1:0]   w_shifted;
  logic               w_carry_out;
  logic               w_do_shift;
  logic [WIDTH-1:0]   w_data_next;
  logic               w_carry_next;

  logic               r_valid;
  logic [WIDTH-1:0]   r_data;
  logic [SHAMT_W-1:0] r_shamt;
  logic [2:0]         r_op;
  logic               r_carry;

  // Shift or rotate by STEP and pick the last bit that leaves the word
  always_comb begin
    w_right = i_data >> STEP;
    w_left  = i_data << STEP;
    if (is_right(i_op)) begin
      if (is_rotate(i_op)) begin
        w_shifted = w_right | (i_data << (WIDTH - STEP));
      end else if (i_op == OP_ASR) begin
        w_shifted = w_right | ({WIDTH{i_data[WIDTH-1]}} << (WIDTH - STEP));
      end else begin
        w_shifted = w_right;
      end
      w_carry_out = i_data[STEP-1];
    end else begin
      w_shifted   = is_rotate(i_op) ? (w_left | (i_data >> (WIDTH - STEP))) : w_left;
      w_carry_out = i_data[WIDTH-STEP];
    end
    w_do_shift   = i_shamt[STAGE_IDX] && is_shift_op(i_op);
    w_data_next  = w_do_shift ? w_shifted : i_data;
    w_carry_next = w_do_shift ? w_carry_out : i_carry;
  end

  // Stage register; bubbles travel with the beat and everything freezes on stall
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_shamt <= '0;
      r_op    <= 3'd0;
      r_carry <= 1'b0;
    end else if (i_adv) begin
      r_valid <= i_valid;
      r_data  <= w_data_next;
      r_shamt <= i_shamt;
      r_op    <= i_op;
      r_carry <= w_carry_next;
    end
  end

  if (STAGE_IDX == SHAMT_W - 1) begin : g_zero
    logic r_zero;
    // Zero flag is registered alongside the final data so it stalls and resets with it
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_zero <= 1'b0;
      end else if (i_adv) begin
        r_zero <= (w_data_next == '0);
      end
    end
    assign o_zero = r_zero;
  end else begin : g_no_zero
    assign o_zero = 1'b0;
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_shamt = r_shamt;
  assign o_op    = r_op;
  assign o_carry = r_carry;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - streaming multi-mode barrel shifter, one stage per shamt bit
module pipelined_barrel_shifter
  import barrel_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [2:0]               in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_carry,
  output logic                     out_zero
);

  localparam int SHAMT_W = $clog2(WIDTH);

  if ((WIDTH < 2) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
    $error("pipelined_barrel_shifter: WIDTH must be a power of two >= 2");
  end

  logic                              w_adv;
  logic [SHAMT_W:0]                  w_valid;
  logic [SHAMT_W:0][WIDTH-1:0]       w_data;
  logic [SHAMT_W:0][SHAMT_W-1:0]     w_shamt;
  logic [SHAMT_W:0][2:0]             w_op;
  logic [SHAMT_W:0]                  w_carry;
  logic [SHAMT_W-1:0]                w_zero;
  logic                              w_unused_tail;

  // A full output that nobody takes is the only thing that can stall the pipe
  assign w_adv    = !w_valid[SHAMT_W] || out_ready;
  assign in_ready = w_adv;

  assign w_valid[0] = in_valid;
  assign w_data[0]  = in_data;
  assign w_shamt[0] = in_shamt;
  assign w_op[0]    = in_op;
  assign w_carry[0] = 1'b0;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    barrel_shift_stage #(
      .WIDTH     (WIDTH),
      .STAGE_IDX (k)
    ) u_stage (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_adv   (w_adv),
      .i_valid (w_valid[k]),
      .i_data  (w_data[k]),
      .i_shamt (w_shamt[k]),
      .i_op    (w_op[k]),
      .i_carry (w_carry[k]),
      .o_valid (w_valid[k+1]),
      .o_data  (w_data[k+1]),
      .o_shamt (w_shamt[k+1]),
      .o_op    (w_op[k+1]),
      .o_carry (w_carry[k+1]),
      .o_zero  (w_zero[k])
    );
  end

  assign out_valid = w_valid[SHAMT_W];
  assign out_data  = w_data[SHAMT_W];
  assign out_carry = w_carry[SHAMT_W];
  assign out_zero  = w_zero[SHAMT_W-1];

  // Shamt/op leaving the last stage and the inner stages' tied-off zero flags go nowhere
  assign w_unused_tail = ^{w_shamt[SHAMT_W], w_op[SHAMT_W], w_zero};

endmodule
